shift_sequencer: RTL and testbench

Multi-cycle variable-amount shift/rotate engine built around a single fixed-step shifter datapath. Accepts one operand plus a runtime shift amount, direction and rotate/logical mode over a valid/ready handshake. Decomposes the amount into power-of-two steps and applies them one per cycle. Returns the result over a second valid/ready handshake. Used wherever a full combinational barrel shifter is too costly in area.

---
 rtl/shift_pkg.sv | 16 +
 rtl/shift_step.sv | 46 ++++
 rtl/shift_sequencer.sv | 139 +++++++++++++
 tb/tb_shift_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift/rotate sequencer.
// Direction and mode encodings match the in_dir / in_rot port meanings.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic MODE_ROT  = 1'b1;
    localparam logic MODE_LOG  = 1'b0;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by 2^k in the given direction and mode.
// Each power-of-two amount is a fixed-wiring slice; k only selects among them.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned AMT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [AMT_WIDTH-1:0]  k,
    input  logic                  dir,
    input  logic                  rot,
    output logic [DATA_WIDTH-1:0] result
);

    logic [AMT_WIDTH-1:0][DATA_WIDTH-1:0] slice;

    for (genvar i = 0; i < AMT_WIDTH; i++) begin : g_slice
        localparam int unsigned Step = 1 << i;

        logic [DATA_WIDTH-1:0] shl;
        logic [DATA_WIDTH-1:0] shr;
        logic [DATA_WIDTH-1:0] wrap_l;
        logic [DATA_WIDTH-1:0] wrap_r;

        assign shl    = data << Step;
        assign shr    = data >> Step;
        // Bits pushed off one end, realigned to the vacated end for rotate.
        assign wrap_l = data >> (DATA_WIDTH - Step);
        assign wrap_r = data << (DATA_WIDTH - Step);

        assign slice[i] = (dir == DIR_LEFT) ?
                          ((rot == MODE_ROT) ? (shl | wrap_l) : shl) :
                          ((rot == MODE_ROT) ? (shr | wrap_r) : shr);
    end

    always_comb begin
        result = data;
        for (int i = 0; i < AMT_WIDTH; i++) begin
            if (k == AMT_WIDTH'(i)) begin
                result = slice[i];
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable shift/rotate engine: one power-of-two step per cycle, MSB step first.
// Request and result each use a valid/ready handshake; outputs come straight from flops.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned AMT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [AMT_WIDTH-1:0]  in_amt,
    input  logic                  in_dir,
    input  logic                  in_rot,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [AMT_WIDTH-1:0]  amt_q, amt_d;
    logic [AMT_WIDTH-1:0]  k_q, k_d;
    logic                  dir_q, dir_d;
    logic                  rot_q, rot_d;
    logic                  out_valid_q, out_valid_d;

    logic [DATA_WIDTH-1:0] step_out;
    logic [AMT_WIDTH-1:0]  amt_shifted;
    logic                  amt_bit;
    logic                  last_step;

    shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .AMT_WIDTH  (AMT_WIDTH)
    ) u_step (
        .data   (data_q),
        .k      (k_q),
        .dir    (dir_q),
        .rot    (rot_q),
        .result (step_out)
    );

    assign amt_shifted = amt_q >> k_q;
    assign amt_bit     = amt_shifted[0];
    assign last_step   = (k_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
    end

    // Datapath and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            amt_q       <= '0;
            k_q         <= '0;
            dir_q       <= 1'b0;
            rot_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            amt_q       <= amt_d;
            k_q         <= k_d;
            dir_q       <= dir_d;
            rot_q       <= rot_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        data_d      = data_q;
        amt_d       = amt_q;
        k_d         = k_q;
        dir_d       = dir_q;
        rot_d       = rot_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d = in_data;
                    amt_d  = in_amt;
                    dir_d  = in_dir;
                    rot_d  = in_rot;
                    k_d    = AMT_WIDTH'(AMT_WIDTH - 1);
                end
            end
            SHIFT: begin
                if (amt_bit) begin
                    data_d = step_out;
                end
                // Raise out_valid together with the final step so the result lands in DONE.
                if (last_step) begin
                    out_valid_d = 1'b1;
                end else begin
                    k_d = k_q - AMT_WIDTH'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: bit-at-a-time reference model checked every cycle,
// plus directed cases with literal expectations, backpressure, mid-operation reset and random ops.
module tb_shift_sequencer;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] in_amt = '0;
    logic          in_dir = 1'b0;
    logic          in_rot = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          busy;

    int n_checks = 0;
    int n_err    = 0;
    int n_xfer   = 0;
    bit cmp_en   = 1'b0;

    shift_sequencer #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_rot    (in_rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: move one bit position at a time, amt times.
    function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] d, input int amt,
                                                input bit dir, input bit rot);
        logic [DW-1:0] r;
        r = d;
        for (int i = 0; i < amt; i++) begin
            if (dir) r = {r[DW-2:0], rot ? r[DW-1] : 1'b0};
            else     r = {rot ? r[0] : 1'b0, r[DW-1:1]};
        end
        return r;
    endfunction

    // Transaction-level model: 0 = waiting for request, 1 = working, 2 = result offered.
    int            m_state = 0;
    int            m_cnt   = 0;
    logic [DW-1:0] m_res   = '0;
    bit            m_zero  = 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            m_cnt   = 0;
            m_zero  = 1'b1;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    m_state = 1;
                    m_cnt   = 0;
                    m_res   = ref_shift(in_data, int'(in_amt), in_dir, in_rot);
                    m_zero  = 1'b0;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == AW) m_state = 2;
                end
                default: if (out_ready) m_state = 0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) n_xfer++;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc in_ready", 32'(in_ready), 32'(m_state == 0));
            chk("cyc busy", 32'(busy), 32'(m_state != 0));
            chk("cyc out_valid", 32'(out_valid), 32'(m_state == 2));
            if (m_state == 2) chk("cyc out_data", 32'(out_data), 32'(m_res));
            if (m_zero) chk("cyc out_data cleared", 32'(out_data), 32'h0);
        end
    end

    task automatic run_op(input logic [DW-1:0] d, input logic [AW-1:0] a, input bit dir,
                          input bit rot, input logic [DW-1:0] exp, input string name,
                          input int stall);
        int n;
        chk({name, " ready before"}, 32'(in_ready), 32'h1);
        in_data   = d;
        in_amt    = a;
        in_dir    = dir;
        in_rot    = rot;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble the operand inputs; the captured request must be unaffected.
        in_data  = DW'($urandom);
        in_amt   = AW'($urandom);
        in_dir   = 1'($urandom);
        in_rot   = 1'($urandom);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        // Edge count from accept to the first edge that can hand the result off.
        chk({name, " latency"}, 32'(n + 1), 32'(AW + 1));
        chk({name, " data"}, 32'(out_data), 32'(exp));
        repeat (stall) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, " ready after"}, 32'(in_ready), 32'h1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int n;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        bit dr, rt;

        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;
        chk("reset in_ready", 32'(in_ready), 32'h1);
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data", 32'(out_data), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);

        // Pin the reference model itself.
        chk("model rol4", 32'(ref_shift(16'h8001, 4, 1'b1, 1'b1)), 32'h0018);
        chk("model ror1", 32'(ref_shift(16'h8001, 1, 1'b0, 1'b1)), 32'hC000);

        run_op(16'h8001, 4'd4, 1'b1, 1'b1, 16'h0018, "rol4", 0);
        run_op(16'h8001, 4'd1, 1'b0, 1'b0, 16'h4000, "shr1", 0);
        run_op(16'h8001, 4'd1, 1'b0, 1'b1, 16'hC000, "ror1", 1);
        run_op(16'hFFFF, 4'd15, 1'b1, 1'b0, 16'h8000, "shl15", 0);
        run_op(16'hFFFF, 4'd0, 1'b1, 1'b0, 16'hFFFF, "amt0", 0);

        // Backpressure: result held 10 cycles while a second request is offered.
        in_data  = 16'h1234;
        in_amt   = 4'd3;
        in_dir   = 1'b1;
        in_rot   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp valid", 32'(out_valid), 32'h1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hAAAA;
            @(posedge clk);
            #1;
            chk("bp hold data", 32'(out_data), 32'h91A0);
            chk("bp in_ready low", 32'(in_ready), 32'h0);
        end
        in_valid  = 1'b0;
        x0        = n_xfer;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp one transfer", 32'(n_xfer - x0), 32'h1);
        chk("bp ready after", 32'(in_ready), 32'h1);
        chk("bp valid dropped", 32'(out_valid), 32'h0);

        // Reset during SHIFT discards the operation.
        in_data  = 16'h00F0;
        in_amt   = 4'd2;
        in_dir   = 1'b1;
        in_rot   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst in_ready", 32'(in_ready), 32'h1);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst out_data", 32'(out_data), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        x0        = n_xfer;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("rst no stale result", 32'(n_xfer - x0), 32'h0);
        run_op(16'h00F0, 4'd2, 1'b1, 1'b1, 16'h03C0, "after rst", 0);

        // Random regression with random result stalls.
        for (int i = 0; i < 40; i++) begin
            d  = DW'($urandom);
            a  = AW'($urandom);
            dr = 1'($urandom);
            rt = 1'($urandom);
            run_op(d, a, dr, rt, ref_shift(d, int'(a), dr, rt), "rand",
                   int'($urandom_range(0, 3)));
        end

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
